// File: rtl/ex_div_ctrl_pkg.sv
// Shared types and constants for the EX-stage iterative divider.
package ex_div_ctrl_pkg;

  localparam int DIV_WIDTH = 32;

  localparam logic RST_ENABLE   = 1'b1;
  localparam logic START_ENABLE = 1'b1;
  localparam logic ANNUL_ENABLE = 1'b1;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    DIVZERO = 2'd1,
    RUN     = 2'd2,
    DONE    = 2'd3
  } div_state_t;

  typedef struct packed {
    logic [DIV_WIDTH-1:0] rem;
    logic [DIV_WIDTH-1:0] quo;
  } div_result_t;

endpackage

// File: rtl/ex_div_ctrl_if.sv
// EX <-> divider handshake bundle; master is the EX stage, slave is the divider.
interface ex_div_ctrl_if
  import ex_div_ctrl_pkg::*;
#(
  parameter int WIDTH = DIV_WIDTH
);
  logic               div_start_i;
  logic               div_annul_i;
  logic               div_signed_i;
  logic [WIDTH-1:0]   div_opdata1_i;
  logic [WIDTH-1:0]   div_opdata2_i;
  logic [2*WIDTH-1:0] div_result_o;
  logic               div_ready_o;
  logic               div_busy_o;

  modport master (
    output div_start_i, div_annul_i, div_signed_i, div_opdata1_i, div_opdata2_i,
    input  div_result_o, div_ready_o, div_busy_o
  );

  modport slave (
    input  div_start_i, div_annul_i, div_signed_i, div_opdata1_i, div_opdata2_i,
    output div_result_o, div_ready_o, div_busy_o
  );
endinterface

// File: rtl/ex_div_ctrl_div_step.sv
// One radix-2 restoring division iteration on a {rem, quo} pair.
module div_step #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] rem,
  input  logic [WIDTH-1:0] quo,
  input  logic [WIDTH-1:0] dsor,
  output logic [WIDTH-1:0] rem_o,
  output logic [WIDTH-1:0] quo_o
);
  logic [WIDTH:0] rem_sh;

  // The remainder is always below the divisor, so the low WIDTH bits of the difference are exact.
  always_comb begin
    rem_sh = {rem, quo[WIDTH-1]};
    if (rem_sh >= {1'b0, dsor}) begin
      rem_o = rem_sh[WIDTH-1:0] - dsor;
      quo_o = {quo[WIDTH-2:0], 1'b1};
    end else begin
      rem_o = rem_sh[WIDTH-1:0];
      quo_o = {quo[WIDTH-2:0], 1'b0};
    end
  end
endmodule

// File: rtl/ex_div_ctrl.sv
// Multi-cycle DIV/DIVU sequencer for the EX stage: stalls EX while busy, returns {rem, quo}.
// Signed division is built only when EX_DIV_SIGNED_EN is defined; otherwise every divide is unsigned.
module ex_div_ctrl
  import ex_div_ctrl_pkg::*;
#(
  parameter int WIDTH = DIV_WIDTH
) (
  input logic         clk,
  input logic         rst,
  ex_div_ctrl_if.slave div
);
  localparam int CNT_W = $clog2(WIDTH + 1);

  div_state_t         state, state_nxt;
  logic [CNT_W-1:0]   cnt;
  logic [WIDTH-1:0]   rem_r, quo_r, dsor_r;
  logic [WIDTH-1:0]   rem_nx, quo_nx;
  logic [2*WIDTH-1:0] result_r;
  logic               accept, annul, busy;

`ifdef EX_DIV_SIGNED_EN
  logic sgn_r, neg1_r, neg2_r;

  function automatic logic [WIDTH-1:0] mag(input logic [WIDTH-1:0] x, input logic sgn);
    return (sgn && x[WIDTH-1]) ? -x : x;
  endfunction

  function automatic logic [2*WIDTH-1:0] sign_fix(input logic [WIDTH-1:0] rem,
                                                  input logic [WIDTH-1:0] quo,
                                                  input logic sgn, n1, n2);
    logic [WIDTH-1:0] r, q;
    q = (sgn && (n1 ^ n2)) ? -quo : quo;
    r = (sgn && n1) ? -rem : rem;
    return {r, q};
  endfunction
`else
  logic unused_signed;
  assign unused_signed = div.div_signed_i;
`endif

  assign annul  = (div.div_annul_i == ANNUL_ENABLE);
  assign accept = (state == IDLE) && (div.div_start_i == START_ENABLE) && !annul;

  div_step #(.WIDTH(WIDTH)) u_step (
    .rem   (rem_r),
    .quo   (quo_r),
    .dsor  (dsor_r),
    .rem_o (rem_nx),
    .quo_o (quo_nx)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst == RST_ENABLE) state <= IDLE;
    else                   state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    busy      = 1'b0;
    case (state)
      IDLE: begin
        if (accept) begin
          busy      = 1'b1;
          state_nxt = (div.div_opdata2_i == '0) ? DIVZERO : RUN;
        end
      end
      DIVZERO: begin
        busy      = 1'b1;
        state_nxt = annul ? IDLE : DONE;
      end
      RUN: begin
        busy = 1'b1;
        if (annul)                      state_nxt = IDLE;
        else if (cnt == CNT_W'(WIDTH))  state_nxt = DONE;
      end
      DONE: begin
        if (div.div_start_i != START_ENABLE) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Datapath: operands latched at acceptance, one restoring step per RUN edge, then fixup.
  always_ff @(posedge clk or posedge rst) begin
    if (rst == RST_ENABLE) begin
      cnt      <= '0;
      rem_r    <= '0;
      quo_r    <= '0;
      dsor_r   <= '0;
      result_r <= '0;
`ifdef EX_DIV_SIGNED_EN
      sgn_r    <= 1'b0;
      neg1_r   <= 1'b0;
      neg2_r   <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            cnt <= '0;
            if (div.div_opdata2_i == '0) begin
              rem_r <= div.div_opdata1_i;
            end else begin
              rem_r <= '0;
`ifdef EX_DIV_SIGNED_EN
              quo_r  <= mag(div.div_opdata1_i, div.div_signed_i);
              dsor_r <= mag(div.div_opdata2_i, div.div_signed_i);
              sgn_r  <= div.div_signed_i;
              neg1_r <= div.div_opdata1_i[WIDTH-1];
              neg2_r <= div.div_opdata2_i[WIDTH-1];
`else
              quo_r  <= div.div_opdata1_i;
              dsor_r <= div.div_opdata2_i;
`endif
            end
          end
        end
        DIVZERO: begin
          if (!annul) result_r <= {rem_r, {WIDTH{1'b1}}};
        end
        RUN: begin
          if (!annul) begin
            if (cnt == CNT_W'(WIDTH)) begin
`ifdef EX_DIV_SIGNED_EN
              result_r <= sign_fix(rem_r, quo_r, sgn_r, neg1_r, neg2_r);
`else
              result_r <= {rem_r, quo_r};
`endif
            end else begin
              rem_r <= rem_nx;
              quo_r <= quo_nx;
              cnt   <= cnt + CNT_W'(1);
            end
          end
        end
        default: ;
      endcase
    end
  end

  assign div.div_result_o = result_r;
  assign div.div_ready_o  = (state == DONE);
  assign div.div_busy_o   = busy;
endmodule

// File: tb/tb_ex_div_ctrl.sv
// Scoreboard bench for ex_div_ctrl: random and directed divides against an arithmetic model.
module tb_ex_div_ctrl;
  localparam int W = 32;
`ifdef EX_DIV_SIGNED_EN
  localparam bit SIGNED_EN = 1'b1;
`else
  localparam bit SIGNED_EN = 1'b0;
`endif

  typedef struct {
    logic [2*W-1:0] res;
    int             e;
    bit             dz;
  } exp_t;

  logic clk = 1'b0;
  logic rst;
  int   vecs = 0;
  int   errs = 0;
  int   edge_cnt = 0;
  logic ready_q = 1'b0;
  exp_t sbq[$];

  ex_div_ctrl_if #(.WIDTH(W)) div_if ();

  ex_div_ctrl #(.WIDTH(W)) dut (
    .clk (clk),
    .rst (rst),
    .div (div_if.slave)
  );

  always #5 clk = ~clk;
  always @(posedge clk) edge_cnt++;

  function automatic logic [2*W-1:0] ref_div(input logic [W-1:0] a, input logic [W-1:0] b,
                                             input bit s);
    longint sa, sb, q, r;
    logic [W-1:0] uq, ur;
    if (b == '0) return {a, {W{1'b1}}};
    if (s && SIGNED_EN) begin
      sa = longint'($signed(a));
      sb = longint'($signed(b));
      q  = sa / sb;
      r  = sa % sb;
      return {r[W-1:0], q[W-1:0]};
    end
    uq = a / b;
    ur = a % b;
    return {ur, uq};
  endfunction

  task automatic chk(input string name, input logic [2*W-1:0] act, input logic [2*W-1:0] exp);
    vecs++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Monitor: pops the scoreboard on each rising ready and checks result and latency.
  always @(negedge clk) begin
    if (rst) begin
      ready_q = 1'b0;
    end else begin
      if (div_if.div_ready_o && !ready_q) begin
        if (sbq.size() == 0) begin
          chk("unexpected_ready", 1, 0);
        end else begin
          exp_t e;
          int lat;
          e = sbq.pop_front();
          chk("result", div_if.div_result_o, e.res);
          lat = edge_cnt - e.e;
          vecs++;
          if (e.dz ? (lat < 2 || lat > 3) : (lat != W + 2)) begin
            errs++;
            $display("FAIL latency: got %0d edges, expected %0d", lat, e.dz ? 2 : W + 2);
          end
        end
      end
      ready_q = div_if.div_ready_o;
    end
  end

  task automatic run_div(input logic [W-1:0] a, input logic [W-1:0] b, input bit s, input int hold);
    exp_t e;
    int n;
    bit busy_ok;
    logic [2*W-1:0] held;
    @(negedge clk);
    div_if.div_opdata1_i = a;
    div_if.div_opdata2_i = b;
    div_if.div_signed_i  = s;
    div_if.div_annul_i   = 1'b0;
    div_if.div_start_i   = 1'b1;
    #1;
    chk("busy_on_request", div_if.div_busy_o, 1);
    e.res = ref_div(a, b, s);
    e.e   = edge_cnt;
    e.dz  = (b == '0);
    sbq.push_back(e);
    busy_ok = 1'b1;
    n = 0;
    @(negedge clk);
    while (!div_if.div_ready_o && n < W + 10) begin
      if (!div_if.div_busy_o) busy_ok = 1'b0;
      div_if.div_opdata1_i = $urandom;
      div_if.div_opdata2_i = $urandom;
      div_if.div_signed_i  = ~s;
      @(negedge clk);
      n++;
    end
    if (!div_if.div_ready_o) chk("ready_timeout", 0, 1);
    chk("busy_while_running", busy_ok, 1);
    chk("busy_low_in_done", div_if.div_busy_o, 0);
    held = div_if.div_result_o;
    for (int i = 0; i < hold; i++) begin
      div_if.div_annul_i = (i == 1);
      @(negedge clk);
      chk("done_ready_hold", div_if.div_ready_o, 1);
      chk("done_result_hold", div_if.div_result_o, held);
    end
    div_if.div_annul_i = 1'b0;
    div_if.div_start_i = 1'b0;
    @(negedge clk);
    chk("ready_drop", div_if.div_ready_o, 0);
    chk("result_kept", div_if.div_result_o, held);
  endtask

  initial begin
    logic [W-1:0] a, b;
    rst = 1'b1;
    div_if.div_start_i   = 1'b0;
    div_if.div_annul_i   = 1'b0;
    div_if.div_signed_i  = 1'b0;
    div_if.div_opdata1_i = '0;
    div_if.div_opdata2_i = '0;
    repeat (3) @(negedge clk);
    chk("reset_result", div_if.div_result_o, 0);
    chk("reset_ready", div_if.div_ready_o, 0);
    chk("reset_busy", div_if.div_busy_o, 0);
    rst = 1'b0;

    run_div(32'd100, 32'd7, 1'b0, 0);
    run_div(32'hFFFF_FFF9, 32'd2, 1'b1, 1);
    run_div(32'h8000_0000, 32'hFFFF_FFFF, 1'b1, 0);
    run_div(32'd5, 32'd0, 1'b0, 2);
    run_div(32'hFFFF_FFFB, 32'd0, 1'b1, 0);
    run_div(32'd0, 32'd5, 1'b0, 0);
    run_div(32'hFFFF_FFFF, 32'd1, 1'b0, 0);
    run_div(32'd7, 32'hFFFF_FFF9, 1'b1, 0);
    run_div(32'd1234567, 32'd1234567, 1'b0, 5);

    // Flush partway through a divide, then start a fresh one.
    @(negedge clk);
    div_if.div_opdata1_i = 32'd1000;
    div_if.div_opdata2_i = 32'd3;
    div_if.div_signed_i  = 1'b0;
    div_if.div_start_i   = 1'b1;
    repeat (10) @(negedge clk);
    div_if.div_annul_i = 1'b1;
    div_if.div_start_i = 1'b0;
    @(negedge clk);
    chk("annul_busy", div_if.div_busy_o, 0);
    chk("annul_ready", div_if.div_ready_o, 0);
    div_if.div_annul_i = 1'b0;
    run_div(32'd9, 32'd3, 1'b0, 0);

    // Start and annul together in IDLE must not be accepted.
    @(negedge clk);
    div_if.div_start_i = 1'b1;
    div_if.div_annul_i = 1'b1;
    #1;
    chk("start_annul_busy", div_if.div_busy_o, 0);
    repeat (3) @(negedge clk);
    chk("start_annul_ready", div_if.div_ready_o, 0);
    div_if.div_start_i = 1'b0;
    div_if.div_annul_i = 1'b0;

    // Asynchronous reset in the middle of a RUN.
    @(negedge clk);
    div_if.div_opdata1_i = 32'd77777;
    div_if.div_opdata2_i = 32'd13;
    div_if.div_start_i   = 1'b1;
    repeat (15) @(negedge clk);
    div_if.div_start_i = 1'b0;
    rst = 1'b1;
    #1;
    chk("midrun_rst_result", div_if.div_result_o, 0);
    chk("midrun_rst_ready", div_if.div_ready_o, 0);
    chk("midrun_rst_busy", div_if.div_busy_o, 0);
    @(negedge clk);
    rst = 1'b0;
    run_div(32'd77777, 32'd13, 1'b0, 0);

    for (int k = 0; k < 24; k++) begin
      case ($urandom_range(0, 5))
        0: b = '0;
        1: b = $urandom_range(1, 15);
        2: b = '1;
        default: b = $urandom;
      endcase
      a = ($urandom_range(0, 3) == 0) ? W'($urandom_range(0, 255)) : $urandom;
      run_div(a, b, 1'($urandom_range(0, 1)), $urandom_range(0, 3));
    end

    repeat (2) @(negedge clk);
    chk("scoreboard_drained", sbq.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end
endmodule
